// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame widths, transmitter states and the CRC fold
// used by both the transmitter and the speedhandler receive path.
package dshot_pkg;
   localparam int DSHOT_FRAME_W = 16;
   localparam int DSHOT_THR_W   = 11;
   localparam int DSHOT_CRC_W   = 4;

   typedef enum logic [1:0] {IDLE, BIT, GAP} dshot_tx_state_t;

   function automatic logic [DSHOT_CRC_W-1:0] dshot_crc(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction
endpackage

// File: rtl/dshot_crc.sv
// Combinational DShot CRC over the 12-bit {throttle, telemetry} payload; inv selects
// the inverted CRC used by bidirectional DShot.
module dshot_crc
   import dshot_pkg::*;
(
   input  logic [11:0]            v,
   input  logic                   inv,
   output logic [DSHOT_CRC_W-1:0] crc
);
   assign crc = dshot_pkg::dshot_crc(v) ^ {DSHOT_CRC_W{inv}};
endmodule

// File: rtl/dshot_tx.sv
// DShot transmitter: serializes {throttle, telemetry, crc} MSB-first as pulse-width bits.
// Define DSHOT_BIDIR_EN for bidirectional DShot (inverted CRC, line idles high).
module dshot_tx
   import dshot_pkg::*;
#(
   parameter int BIT_CYCLES = 53,
   parameter int T1H_CYCLES = 40,
   parameter int T0H_CYCLES = 20,
   parameter int GAP_CYCLES = 32
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DSHOT_THR_W-1:0] throttle,
   input  logic                   telemetry,
   input  logic                   frame_valid,
   output logic                   frame_ready,
   output logic                   dshot_out,
   output logic                   busy
);
`ifdef DSHOT_BIDIR_EN
   localparam logic BIDIR = 1'b1;
`else
   localparam logic BIDIR = 1'b0;
`endif
   localparam int MAX_CYC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC);
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
   localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
   localparam logic [3:0]    IDX_MSB  = 4'(DSHOT_FRAME_W - 1);

   dshot_tx_state_t          state, state_nx;
   logic [CW-1:0]            cyc, cyc_nx;
   logic [3:0]               bit_idx, idx_nx;
   logic [DSHOT_FRAME_W-1:0] sreg, sreg_nx, frame;
   logic [DSHOT_CRC_W-1:0]   crc;
   logic                     pulse;

   dshot_crc u_crc (
      .v   ({throttle, telemetry}),
      .inv (BIDIR),
      .crc (crc)
   );
   assign frame = {throttle, telemetry, crc};

   // The frame shifts left at each bit boundary, so the current bit is always the MSB.
   always_comb begin
      state_nx = state;
      cyc_nx   = cyc;
      idx_nx   = bit_idx;
      sreg_nx  = sreg;
      pulse    = 1'b0;
      case (state)
         IDLE: begin
            if (frame_valid) begin
               state_nx = BIT;
               sreg_nx  = frame;
               idx_nx   = IDX_MSB;
               cyc_nx   = '0;
            end
         end
         BIT: begin
            pulse = cyc < (sreg[DSHOT_FRAME_W-1] ? T1H : T0H);
            if (cyc == BIT_LAST) begin
               cyc_nx  = '0;
               sreg_nx = sreg << 1;
               if (bit_idx == 4'd0) state_nx = GAP;
               else                 idx_nx   = bit_idx - 4'd1;
            end else begin
               cyc_nx = cyc + 1'b1;
            end
         end
         GAP: begin
            if (cyc == GAP_LAST) begin
               state_nx = IDLE;
               cyc_nx   = '0;
            end else begin
               cyc_nx = cyc + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cyc       <= '0;
         bit_idx   <= '0;
         sreg      <= '0;
         dshot_out <= BIDIR;
      end else begin
         state     <= state_nx;
         cyc       <= cyc_nx;
         bit_idx   <= idx_nx;
         sreg      <= sreg_nx;
         dshot_out <= pulse ^ BIDIR;
      end
   end

   assign frame_ready = (state == IDLE);
   assign busy        = (state != IDLE);
endmodule
